triple_demux_buffer: RTL and testbench
======================================

# triple_demux_buffer

Routes one valid/ready stream to one of three destination ports, picked per transfer by a 2-bit selector; the distributing counterpart to the three-input selector mux in the adder datapath. A single-entry holding register sits between the source and the destinations. The selector is captured with the data, so each destination sees only the words addressed to it. Sits between the adder result stage and the display/validity consumers.

## Interface
- WIDTH, 4: data width of input and all three outputs
- CNT_W, 8: width of per-port transfer counters (DEMUX_STATS_EN only)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source presents in_data/in_sel
- in_ready  out  1  block accepts this cycle
- in_data  in  WIDTH  payload
- in_sel  in  2  destination: 0→port zero, 1→port one, 2 or 3→port two
- zero_valid / one_valid / two_valid  out  1 each  per-port valid
- zero_ready / one_ready / two_ready  in  1 each  per-port ready
- zero_data / one_data / two_data  out  WIDTH each  per-port payload, all driven from the holding register
- cnt_zero / cnt_one / cnt_two  out  CNT_W each  transfer counts (DEMUX_STATS_EN only)

## Operation
- States: EMPTY (holding register free) and FULL (holding word plus latched dest).
- EMPTY: in_ready=1; all *_valid=0. On in_valid, capture in_data and dest=(in_sel==0?0:in_sel==1?1:2); go to FULL.
- FULL: exactly one *_valid=1, the one for latched dest. The other two stay 0.
- FULL, handshake completes (dest valid & dest ready):
  - with in_valid=1: load the new word and dest in the same cycle, stay FULL.
  - with in_valid=0: go to EMPTY.
- FULL, no handshake: hold data and dest stable; in_valid is ignored.
- in_ready = (state==EMPTY) | (selected dest ready). This is combinational from *_ready; there is no combinational path from in_valid.
- Readies of unselected ports have no effect.
- in_sel is sampled only on an accepted input transfer.
- All three *_data outputs carry the holding register. Consumers qualify it with their own *_valid.

## Timing
- Reset (async assert, sync-release): state=EMPTY, holding register=0, dest=0, all *_valid=0. in_ready=1 once rst_n is high. Counters=0.
- Latency: word accepted at edge N, presented on the dest port from N+1. It is retired at the first edge where dest ready is high.
- Throughput: one word per cycle when consumers hold ready high.
- Reset asserted mid-transfer: the held word is dropped, outputs go to reset values immediately, and no handshake is reported.
- Destination changing between consecutive words: the new dest valid rises in the cycle after the old port's handshake. The old port's valid deasserts on the same edge.

## Configuration
- DEMUX_STATS_EN defined:
  - cnt_zero/cnt_one/cnt_two are present.
  - Each counts completed output handshakes on its port, +1 per handshake.
  - Each saturates at 2^CNT_W−1 with no wrap, and clears on reset.
- Not defined: counter ports and logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold rst_n=0, drive in_valid=1 → all *_valid=0, in_ready=1; after release, no output valid until the first accepted word.
- Routing: send 0x3 sel=0, 0x5 sel=1, 0xA sel=2, 0xC sel=3, all readies=1 → zero gets 3, one gets 5, two gets A then C, each one cycle after accept; back-to-back with no bubbles.
- Backpressure: in_sel=1, data 0x7, one_ready=0 for 5 cycles, other readies=1 → one_valid=1 with data 7 held, in_ready=0, and new input is not captured; one_ready=1 → retired in that cycle, next word accepted in the same cycle.
- Simultaneous: FULL on port two, two_ready=1 and in_valid=1 sel=0 data 0x9 in the same cycle → two retires; zero_valid=1 with 9 on the next cycle; two_valid=0.
- Reset mid-operation: FULL with zero_ready=0, pulse rst_n low asynchronously mid-cycle → zero_valid drops before the next edge and the word is lost.
- DEMUX_STATS_EN with CNT_W=2: 5 handshakes to port one → cnt_one=3 (saturated), cnt_zero=cnt_two=0.

Source files
------------

// File: rtl/triple_demux_buffer_if.sv
// Stream bundle for triple_demux_buffer: one valid/ready source and three valid/ready destinations.
// The slave modport is the buffer's view, and the master modport is the environment's view.
interface triple_demux_buffer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;

  logic             zero_valid;
  logic             zero_ready;
  logic [WIDTH-1:0] zero_data;
  logic             one_valid;
  logic             one_ready;
  logic [WIDTH-1:0] one_data;
  logic             two_valid;
  logic             two_ready;
  logic [WIDTH-1:0] two_data;

  modport slave (
    input  in_valid, in_data, in_sel,
    output in_ready,
    output zero_valid, zero_data, one_valid, one_data, two_valid, two_data,
    input  zero_ready, one_ready, two_ready
  );

  modport master (
    output in_valid, in_data, in_sel,
    input  in_ready,
    input  zero_valid, zero_data, one_valid, one_data, two_valid, two_data,
    output zero_ready, one_ready, two_ready
  );
endinterface

// File: rtl/triple_demux_buffer.sv
// One-entry buffered 1-to-3 stream demux. The destination is latched together with each word.
// Optional per-port saturating handshake counters are enabled when DEMUX_STATS_EN is defined.
//
// state | meaning
// EMPTY | holding register free, in_ready=1, no output valid
// FULL  | holding word + latched dest, only that port's valid is high
module triple_demux_buffer #(
  parameter int WIDTH = 4
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  triple_demux_buffer_if.slave   bus
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0]     cnt_zero
  , output logic [CNT_W-1:0]     cnt_one
  , output logic [CNT_W-1:0]     cnt_two
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [1:0]       dest, dest_nxt;
  logic             sel_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      hold  <= '0;
      dest  <= 2'd0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      dest  <= dest_nxt;
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    case (dest)
      2'd0:    sel_ready = bus.zero_ready;
      2'd1:    sel_ready = bus.one_ready;
      default: sel_ready = bus.two_ready;
    endcase
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    dest_nxt  = dest;
    case (state)
      EMPTY: begin
        if (bus.in_valid) begin
          hold_nxt  = bus.in_data;
          dest_nxt  = bus.in_sel[1] ? 2'd2 : bus.in_sel;
          state_nxt = FULL;
        end
      end
      FULL: begin
        // in_valid only matters once the current word retires
        if (sel_ready) begin
          if (bus.in_valid) begin
            hold_nxt = bus.in_data;
            dest_nxt = bus.in_sel[1] ? 2'd2 : bus.in_sel;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.in_ready   = (state == EMPTY) | sel_ready;
  assign bus.zero_valid = (state == FULL) & (dest == 2'd0);
  assign bus.one_valid  = (state == FULL) & (dest == 2'd1);
  assign bus.two_valid  = (state == FULL) & (dest == 2'd2);
  assign bus.zero_data  = hold;
  assign bus.one_data   = hold;
  assign bus.two_data   = hold;

`ifdef DEMUX_STATS_EN
  logic hs_zero, hs_one, hs_two;

  assign hs_zero = bus.zero_valid & bus.zero_ready;
  assign hs_one  = bus.one_valid  & bus.one_ready;
  assign hs_two  = bus.two_valid  & bus.two_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_zero <= '0;
      cnt_one  <= '0;
      cnt_two  <= '0;
    end else begin
      if (hs_zero && (cnt_zero != '1)) cnt_zero <= cnt_zero + 1'b1;
      if (hs_one  && (cnt_one  != '1)) cnt_one  <= cnt_one  + 1'b1;
      if (hs_two  && (cnt_two  != '1)) cnt_two  <= cnt_two  + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_triple_demux_buffer.sv
// Directed bench for triple_demux_buffer: reset, routing, backpressure, simultaneous retire/load, and mid-transfer reset.
// It also covers counter saturation when DEMUX_STATS_EN is defined (CNT_W=2).
module tb_triple_demux_buffer;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  triple_demux_buffer_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_STATS_EN
  logic [1:0] cnt_zero, cnt_one, cnt_two;
`endif

  triple_demux_buffer #(
    .WIDTH(WIDTH)
`ifdef DEMUX_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_STATS_EN
    , .cnt_zero (cnt_zero)
    , .cnt_one  (cnt_one)
    , .cnt_two  (cnt_two)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valids(input string tag, input logic z, input logic o, input logic t);
    chk({tag, "_zero_valid"}, {31'd0, bus.zero_valid}, {31'd0, z});
    chk({tag, "_one_valid"},  {31'd0, bus.one_valid},  {31'd0, o});
    chk({tag, "_two_valid"},  {31'd0, bus.two_valid},  {31'd0, t});
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 2'd1);
    bus.zero_ready = 1'b1;
    bus.one_ready  = 1'b1;
    bus.two_ready  = 1'b1;

    // reset held with in_valid high
    cyc(); cyc(); cyc();
    chk_valids("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_data", {28'd0, bus.zero_data}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 2'd0);
    cyc();
    chk_valids("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // routing, back-to-back
    drive(1'b1, 4'h3, 2'd0); cyc();
    chk_valids("r0", 1'b1, 1'b0, 1'b0);
    chk("r0_data", {28'd0, bus.zero_data}, 32'h3);
    chk("r0_in_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 4'h5, 2'd1); cyc();
    chk_valids("r1", 1'b0, 1'b1, 1'b0);
    chk("r1_data", {28'd0, bus.one_data}, 32'h5);
    drive(1'b1, 4'hA, 2'd2); cyc();
    chk_valids("r2", 1'b0, 1'b0, 1'b1);
    chk("r2_data", {28'd0, bus.two_data}, 32'hA);
    drive(1'b1, 4'hC, 2'd3); cyc();
    chk_valids("r3", 1'b0, 1'b0, 1'b1);
    chk("r3_data", {28'd0, bus.two_data}, 32'hC);
    drive(1'b0, 4'h0, 2'd0); cyc();
    chk_valids("r_idle", 1'b0, 1'b0, 1'b0);

    // backpressure on port one; other readies high have no effect
    bus.one_ready = 1'b0;
    drive(1'b1, 4'h7, 2'd1); cyc();
    drive(1'b1, 4'h2, 2'd0);
    for (int i = 0; i < 4; i++) begin
      chk_valids("bp", 1'b0, 1'b1, 1'b0);
      chk("bp_data", {28'd0, bus.one_data}, 32'h7);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cyc();
    end
    chk("bp_last_data", {28'd0, bus.one_data}, 32'h7);
    bus.one_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    chk_valids("bp_next", 1'b1, 1'b0, 1'b0);
    chk("bp_next_data", {28'd0, bus.zero_data}, 32'h2);

    // simultaneous retire on two and load for zero
    drive(1'b1, 4'h6, 2'd2); cyc();
    chk_valids("sim_a", 1'b0, 1'b0, 1'b1);
    chk("sim_a_data", {28'd0, bus.two_data}, 32'h6);
    drive(1'b1, 4'h9, 2'd0); cyc();
    chk_valids("sim_b", 1'b1, 1'b0, 1'b0);
    chk("sim_b_data", {28'd0, bus.zero_data}, 32'h9);
    drive(1'b0, 4'h0, 2'd0); cyc();
    chk_valids("sim_idle", 1'b0, 1'b0, 1'b0);

    // reset asynchronously while port zero is stalled
    bus.zero_ready = 1'b0;
    drive(1'b1, 4'h4, 2'd0); cyc();
    drive(1'b0, 4'h0, 2'd0);
    chk_valids("mr_full", 1'b1, 1'b0, 1'b0);
    chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    chk("mr_hold", {28'd0, bus.zero_data}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk_valids("mr_async", 1'b0, 1'b0, 1'b0);
    chk("mr_async_data", {28'd0, bus.zero_data}, 32'h0);
    chk("mr_async_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    bus.zero_ready = 1'b1;
    cyc();
    chk_valids("mr_lost", 1'b0, 1'b0, 1'b0);

    // five transfers to port one
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 1), 2'd1); cyc();
      chk("burst_one_valid", {31'd0, bus.one_valid}, 32'd1);
      chk("burst_one_data", {28'd0, bus.one_data}, 32'(i + 1));
    end
    drive(1'b0, 4'h0, 2'd0); cyc();
    chk_valids("burst_idle", 1'b0, 1'b0, 1'b0);
`ifdef DEMUX_STATS_EN
    chk("cnt_one_sat", {30'd0, cnt_one}, 32'd3);
    chk("cnt_zero", {30'd0, cnt_zero}, 32'd0);
    chk("cnt_two", {30'd0, cnt_two}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
